mod_rst_seq: RTL and testbench
==============================

// Module: mod_rst_seq
// PURPOSE
//  Reset sequencer directly downstream of the PLL wrapper. Runs on the PLL output clock and
//  synchronises the PLL lock flag. Requires lock to be stable for a qualification window,
//  then releases a clean, synchronously-deasserted active-low reset to the fabric.
//  Re-asserts reset on lock loss and counts lock-loss events for debug.
// PARAMETERS
//  SYNC_STAGES  2     flops in the i_locked synchroniser chain (>=2)
//  LOCK_CYCLES  1024  consecutive cycles synced lock must stay high before hold phase (>=1)
//  HOLD_CYCLES  16    extra cycles reset stays asserted after qualification (>=1)
//  CNT_W        8     width of lock-loss event counter
// PORTS
//  i_clk          in   1      PLL output clock (100.5 MHz in the default build)
//  i_rst_n        in   1      async active-low reset, all flops
//  i_locked       in   1      PLL lock flag, asynchronous to i_clk
//  o_rst_n        out  1      fabric reset, active-low; async assert, sync deassert
//  o_state        out  2      current FSM state (debug)
//  o_loss_cnt     out  CNT_W  saturating count of RUN->WAIT lock-loss events
// BEHAVIOUR
//  - Reset (i_rst_n=0): sync chain=0, state=WAIT, counter=0, o_rst_n=0, o_loss_cnt=0.
//  - i_locked passes through SYNC_STAGES flops; lock_s is the last stage. Only lock_s is used.
//  - FSM states (o_state encoding): WAIT=2'd0, QUAL=2'd1, HOLD=2'd2, RUN=2'd3.
//     WAIT: cnt=0; lock_s=1 -> QUAL.
//     QUAL: lock_s=0 -> WAIT (cnt cleared). Else cnt++; at cnt==LOCK_CYCLES-1 -> HOLD, cnt=0.
//       QUAL lasts exactly LOCK_CYCLES cycles.
//     HOLD: lock_s=0 -> WAIT. Else cnt++; at cnt==HOLD_CYCLES-1 -> RUN.
//       HOLD lasts exactly HOLD_CYCLES cycles.
//     RUN: lock_s=0 -> WAIT; otherwise stay.
//  - o_rst_n is its own flop, not a combinational decode.
//     Loaded with (next_state==RUN) on every edge, so it never glitches.
//  - Release latency: i_locked rise to o_rst_n rise = SYNC_STAGES+LOCK_CYCLES+HOLD_CYCLES+1 edges.
//  - Loss latency: i_locked fall while in RUN to o_rst_n fall = SYNC_STAGES+1 edges.
//  - Lock glitch shorter than the qualification window restarts qualification from WAIT.
//    No partial credit is kept.
//  - cnt width = $clog2(max(LOCK_CYCLES,HOLD_CYCLES))+1; never wraps (cleared on every transition).
//  - o_loss_cnt increments by 1 on each RUN->WAIT transition only.
//     Drops in QUAL/HOLD are not counted. Saturates at 2**CNT_W-1.
//  - The PLL clock may stop while unlocked. The block relies on i_rst_n (async) for a
//    guaranteed safe state, and makes no assumption of clock activity in WAIT.
//  - i_rst_n asserted mid-sequence (any state): immediate async return to reset values,
//    counter included.
// CONFIGURATION
//  RST_SEQ_LOSS_CNT_EN defined: loss counter implemented as above.
//  Not defined: counter logic omitted; o_loss_cnt tied to '0.
//  FSM and o_rst_n timing are identical either way.
// TESTING (SYNC_STAGES=2, LOCK_CYCLES=8, HOLD_CYCLES=4, CNT_W=2)
//  1 Reset: i_rst_n=0, i_locked=1 -> o_rst_n=0, o_state=0, o_loss_cnt=0 while held.
//  2 Release: i_rst_n=1, i_locked 0->1 at edge 0 -> o_rst_n=1 exactly at edge 15, o_state=3;
//    o_rst_n=0 at edge 14.
//  3 Glitch: i_locked low for 3 cycles at QUAL cnt=5 -> o_state returns 0.
//    o_rst_n stays 0; full 15-edge latency counted from re-lock; o_loss_cnt unchanged.
//  4 Loss: in RUN, i_locked 1->0 -> o_rst_n=0 at 3rd edge, o_state=0, o_loss_cnt 0->1.
//  5 Saturation: 5 lock/loss cycles -> o_loss_cnt reads 1,2,3,3,3.
//    Without RST_SEQ_LOSS_CNT_EN it reads 0 throughout.
//  6 Mid-op reset: pulse i_rst_n low during HOLD -> all outputs reset asynchronously
//    (no clock edge needed); sequence restarts.

Source files
------------

// File: rtl/mod_rst_seq.sv
// rtl/mod_rst_seq.sv - PLL lock qualifier and fabric reset sequencer
//
// Purpose:
//   Sits directly downstream of the PLL wrapper and runs on the PLL output clock.
//   It synchronises the PLL lock flag and requires lock to stay high for LOCK_CYCLES.
//   Reset is then held for HOLD_CYCLES more, and after that a synchronously deasserted
//   active-low reset is released to the fabric.
//   Any loss of lock re-asserts reset and restarts qualification from scratch.
//   Losses seen while running are counted for debug.
//
// Optional feature:
//   RST_SEQ_LOSS_CNT_EN - when defined, o_loss_cnt is a saturating count of RUN->WAIT
//   lock-loss events. When undefined, the counter is absent and o_loss_cnt reads zero.
//
// Ports:
//   i_clk       in   1      PLL output clock
//   i_rst_n     in   1      asynchronous active-low reset for every flop
//   i_locked    in   1      PLL lock flag, asynchronous to i_clk
//   o_rst_n     out  1      fabric reset, active-low; async assert, sync deassert
//   o_state     out  2      FSM state (WAIT=0, QUAL=1, HOLD=2, RUN=3)
//   o_loss_cnt  out  CNT_W  saturating RUN->WAIT lock-loss count

module mod_rst_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CYCLES = 1024,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_locked,
  output logic             o_rst_n,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_loss_cnt
);

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_QUAL = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  // The phase counter is sized for the longer of the two windows. It is cleared on
  // every transition, so it never needs to wrap.
  localparam int MAX_CYC = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
  localparam int PH_W    = $clog2(MAX_CYC) + 1;

  localparam logic [PH_W-1:0] LOCK_LAST = PH_W'(LOCK_CYCLES - 1);
  localparam logic [PH_W-1:0] HOLD_LAST = PH_W'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic [1:0]             state_q, state_d;
  logic [PH_W-1:0]        cnt_q, cnt_d;
  logic                   rst_n_q;

  // Lock synchroniser. Only the last stage is ever looked at.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_locked};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Any drop of lock_s sends the FSM straight back to WAIT with the counter cleared.
  // No partial qualification credit survives a glitch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d = '0;
        if (lock_s) state_d = ST_QUAL;
      end
      ST_QUAL: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PH_W'(1);
        end
      end
      ST_HOLD: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PH_W'(1);
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!lock_s) state_d = ST_WAIT;
      end
      default: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  // o_rst_n is registered from the next-state decode. This way it is glitch-free, it
  // rises in the same edge that enters RUN, and it falls in the same edge that leaves RUN.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_WAIT;
      cnt_q   <= '0;
      rst_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_n_q <= (state_d == ST_RUN);
    end
  end

  assign o_rst_n = rst_n_q;
  assign o_state = state_q;

`ifdef RST_SEQ_LOSS_CNT_EN
  logic [CNT_W-1:0] loss_q;
  logic             loss_evt;

  // Only a loss that happens while running counts. Drops during qualification are
  // expected PLL behaviour and are not counted.
  assign loss_evt = (state_q == ST_RUN) && (state_d == ST_WAIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      loss_q <= '0;
    end else if (loss_evt && (loss_q != {CNT_W{1'b1}})) begin
      loss_q <= loss_q + CNT_W'(1);
    end
  end

  assign o_loss_cnt = loss_q;
`else
  assign o_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_mod_rst_seq.sv
// tb/tb_mod_rst_seq.sv - self-checking bench for mod_rst_seq
module tb_mod_rst_seq;

  localparam int SYNC = 2;
  localparam int LOCK = 8;
  localparam int HOLD = 4;
  localparam int CW   = 2;
  localparam int LOSS_MAX = (1 << CW) - 1;
`ifdef RST_SEQ_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          locked;
  logic          o_rst_n;
  logic [1:0]    o_state;
  logic [CW-1:0] o_loss_cnt;

  always #5 clk = ~clk;

  mod_rst_seq #(
    .SYNC_STAGES(SYNC), .LOCK_CYCLES(LOCK), .HOLD_CYCLES(HOLD), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_locked(locked),
    .o_rst_n(o_rst_n), .o_state(o_state), .o_loss_cnt(o_loss_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the synchroniser is a plain delay line of raw lock samples.
  // The phase is derived from how many consecutive high samples have reached the
  // end of that line.
  bit pipe[SYNC];
  int streak;
  int m_loss;

  function automatic int phase_of(input int s);
    if (s == 0) return 0;
    if (s <= LOCK) return 1;
    if (s <= LOCK + HOLD) return 2;
    return 3;
  endfunction

  function automatic logic [1:0] e_state();
    return 2'(phase_of(streak));
  endfunction

  function automatic logic e_rst();
    return (phase_of(streak) == 3);
  endfunction

  function automatic logic [CW-1:0] e_loss();
    return LOSS_EN ? CW'(m_loss) : '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) pipe[i] = 1'b0;
    streak = 0;
    m_loss = 0;
  endtask

  // Advance one clock edge in the DUT and the model, then settle past the edge.
  task automatic tick();
    bit d;
    int prev;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      d = pipe[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = locked;
      prev = phase_of(streak);
      streak = d ? ((streak < 100000) ? streak + 1 : streak) : 0;
      if (prev == 3 && phase_of(streak) == 0 && m_loss < LOSS_MAX) m_loss++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    locked = 1'b1;
    model_reset();
    for (int e = 0; e < 4; e++) begin
      tick();
      n_vec += 3;
      if (o_rst_n !== 1'b0) begin n_err++; $display("FAIL reset_rst: got %0b want 0", o_rst_n); end
      if (o_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", o_state); end
      if (o_loss_cnt !== '0) begin n_err++; $display("FAIL reset_loss: got %0d want 0", o_loss_cnt); end
    end
  endtask

  task automatic test_release();
    locked = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    locked = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      tick();
      n_vec += 2;
      if (o_rst_n !== e_rst()) begin n_err++; $display("FAIL release_rst e%0d: got %0b want %0b", e, o_rst_n, e_rst()); end
      if (o_state !== e_state()) begin n_err++; $display("FAIL release_state e%0d: got %0d want %0d", e, o_state, e_state()); end
      if (e == 14) begin
        n_vec++;
        if (o_rst_n !== 1'b0) begin n_err++; $display("FAIL release_edge14: got %0b want 0", o_rst_n); end
      end
      if (e == 15) begin
        n_vec += 2;
        if (o_rst_n !== 1'b1) begin n_err++; $display("FAIL release_edge15: got %0b want 1", o_rst_n); end
        if (o_state !== 2'd3) begin n_err++; $display("FAIL release_state15: got %0d want 3", o_state); end
      end
    end
  endtask

  task automatic test_glitch();
    logic [CW-1:0] loss0;
    int guard;
    locked = 1'b0;
    repeat (5) tick();
    locked = 1'b1;
    guard = 0;
    while (streak != 6 && guard < 40) begin tick(); guard++; end
    n_vec++;
    if (guard >= 40 || o_state !== 2'd1) begin n_err++; $display("FAIL glitch_qual: state %0d want 1 (guard %0d)", o_state, guard); end
    loss0 = o_loss_cnt;
    locked = 1'b0;
    repeat (3) tick();
    n_vec += 2;
    if (o_state !== 2'd0) begin n_err++; $display("FAIL glitch_wait: got %0d want 0", o_state); end
    if (o_rst_n !== 1'b0) begin n_err++; $display("FAIL glitch_rst: got %0b want 0", o_rst_n); end
    locked = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      n_vec += 3;
      if (o_rst_n !== ((e >= 15) ? 1'b1 : 1'b0)) begin n_err++; $display("FAIL glitch_relock e%0d: got %0b want %0b", e, o_rst_n, (e >= 15)); end
      if (o_state !== e_state()) begin n_err++; $display("FAIL glitch_state e%0d: got %0d want %0d", e, o_state, e_state()); end
      if (o_loss_cnt !== loss0) begin n_err++; $display("FAIL glitch_loss e%0d: got %0d want %0d", e, o_loss_cnt, loss0); end
    end
  endtask

  task automatic test_loss();
    logic [CW-1:0] want;
    n_vec++;
    if (o_state !== 2'd3) begin n_err++; $display("FAIL loss_pre: state %0d want 3", o_state); end
    want = LOSS_EN ? o_loss_cnt + CW'(1) : '0;
    locked = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_vec++;
      if (o_rst_n !== ((e < 3) ? 1'b1 : 1'b0)) begin n_err++; $display("FAIL loss_rst e%0d: got %0b want %0b", e, o_rst_n, (e < 3)); end
    end
    n_vec += 3;
    if (o_state !== 2'd0) begin n_err++; $display("FAIL loss_state: got %0d want 0", o_state); end
    if (o_loss_cnt !== want) begin n_err++; $display("FAIL loss_cnt: got %0d want %0d", o_loss_cnt, want); end
    if (o_loss_cnt !== e_loss()) begin n_err++; $display("FAIL loss_model: got %0d want %0d", o_loss_cnt, e_loss()); end
  endtask

  task automatic test_saturation();
    int exp_list[5];
    exp_list = '{1, 2, 3, 3, 3};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      locked = 1'b1;
      repeat (16) tick();
      n_vec++;
      if (o_state !== 2'd3) begin n_err++; $display("FAIL sat_run%0d: state %0d want 3", k, o_state); end
      locked = 1'b0;
      repeat (4) tick();
      n_vec += 2;
      if (o_loss_cnt !== (LOSS_EN ? CW'(exp_list[k]) : CW'(0))) begin
        n_err++; $display("FAIL sat_cnt%0d: got %0d want %0d", k, o_loss_cnt, LOSS_EN ? exp_list[k] : 0);
      end
      if (o_loss_cnt !== e_loss()) begin n_err++; $display("FAIL sat_model%0d: got %0d want %0d", k, o_loss_cnt, e_loss()); end
    end
  endtask

  task automatic test_midop_reset();
    int guard;
    locked = 1'b1;
    guard = 0;
    while (phase_of(streak) != 2 && guard < 40) begin tick(); guard++; end
    n_vec++;
    if (guard >= 40 || o_state !== 2'd2) begin n_err++; $display("FAIL mid_hold: state %0d want 2", o_state); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec += 3;
    if (o_rst_n !== 1'b0) begin n_err++; $display("FAIL mid_async_rst: got %0b want 0", o_rst_n); end
    if (o_state !== 2'd0) begin n_err++; $display("FAIL mid_async_state: got %0d want 0", o_state); end
    if (o_loss_cnt !== '0) begin n_err++; $display("FAIL mid_async_loss: got %0d want 0", o_loss_cnt); end
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      n_vec += 2;
      if (o_rst_n !== ((e >= 15) ? 1'b1 : 1'b0)) begin n_err++; $display("FAIL mid_restart e%0d: got %0b want %0b", e, o_rst_n, (e >= 15)); end
      if (o_state !== e_state()) begin n_err++; $display("FAIL mid_state e%0d: got %0d want %0d", e, o_state, e_state()); end
    end
  endtask

  task automatic test_random();
    int run;
    run = 0;
    for (int t = 0; t < 3000; t++) begin
      if (run == 0) begin
        locked = ~locked;
        run = locked ? $urandom_range(1, 40) : $urandom_range(1, 6);
      end
      run--;
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_vec += 3;
      if (o_rst_n !== e_rst()) begin n_err++; $display("FAIL rand_rst t%0d: got %0b want %0b", t, o_rst_n, e_rst()); end
      if (o_state !== e_state()) begin n_err++; $display("FAIL rand_state t%0d: got %0d want %0d", t, o_state, e_state()); end
      if (o_loss_cnt !== e_loss()) begin n_err++; $display("FAIL rand_loss t%0d: got %0d want %0d", t, o_loss_cnt, e_loss()); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    locked = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_release();
    test_glitch();
    test_loss();
    test_saturation();
    test_midop_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
